fft_frame_sequencer: RTL and testbench

Controller that sequences the FFT datapath for one audio channel. It gathers FFT_SIZE consecutive audio samples into the FFT input memory over the fft_load/din/add_rd interface, pulses fft_start, and waits for fft_done. It then applies a programmable hold-off before starting the next frame. It sits between the audio sample source (I2S receiver) and the full FFT/decode chain, and reports frame, overrun and timeout status.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/seq_counter.sv | 51 +++++
 rtl/fft_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and constants for the FFT frame sequencer.
//   fft_seq_state_t : sequencer state encoding
//   sample_t        : default-width signed audio sample
//   cnt_width()     : counter width needed to hold a value (at least 1 bit)
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_SIZE_DEF  = 512;
    localparam int FFT_N_DEF     = 9;
    localparam int BIT_WIDTH_DEF = 16;

    typedef logic signed [BIT_WIDTH_DEF-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        BUSY,
        HOLD
    } fft_seq_state_t;

    // Bits needed to represent max_val; never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_counter.sv
// ---------------------------------------------------------------------------
// seq_counter
// Loadable up/down counter with a terminal-count flag.
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   load        : load load_value (has priority over en)
//   load_value  : value to load
//   en          : count one step this cycle
//   up          : 1 = count up, 0 = count down
//   term_value  : count value at which tc is raised
//   tc          : count == term_value
// ---------------------------------------------------------------------------
module seq_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] term_value,
    output logic         tc
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en) begin
            count_d = up ? (count_q + W'(1)) : (count_q - W'(1));
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == term_value);

endmodule

// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
// Gathers FFT_SIZE audio samples into the FFT input memory, pulses fft_start,
// waits for fft_done (bounded by TIMEOUT), then idles HOLDOFF cycles before
// the next frame. Reports completed frames and sticky overrun/timeout flags.
//   clk, reset    : clock, synchronous active-high reset
//   enable        : level-sensitive run request
//   sample_valid  : one-cycle strobe qualifying sample
//   sample        : signed audio sample
//   fft_done      : FFT completion (only honoured in BUSY)
//   fft_load      : write strobe to FFT input memory (1 cycle after strobe)
//   din, add_rd   : write data / address (hold when fft_load=0)
//   fft_start     : one-cycle start pulse, the cycle after the last write
//   busy          : high in every state except IDLE
//   frame_count   : completed frames, wraps
//   overrun       : sticky, sample dropped in START/BUSY/HOLD
//   timeout_err   : sticky, fft_done not seen within TIMEOUT BUSY cycles
// All outputs are registered.
// ---------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = $bits(sample_t),
    parameter int N         = FFT_N_DEF,
    parameter int FFT_SIZE  = FFT_SIZE_DEF,
    parameter int HOLDOFF   = 4800,
    parameter int TIMEOUT   = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        sample_valid,
    input  logic signed [BIT_WIDTH-1:0] sample,
    input  logic                        fft_done,
    output logic                        fft_load,
    output logic signed [BIT_WIDTH-1:0] din,
    output logic        [N-1:0]         add_rd,
    output logic                        fft_start,
    output logic                        busy,
    output logic        [15:0]          frame_count,
    output logic                        overrun,
    output logic                        timeout_err
);

    localparam int           W_TO      = cnt_width(TIMEOUT);
    localparam int           W_HO      = cnt_width(HOLDOFF);
    // HOLDOFF=0 still spends one cycle in HOLD, so it loads the same as 1.
    localparam int           HOLD_LOAD = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;
    localparam logic [N-1:0] LAST_IDX  = N'(FFT_SIZE - 1);

    fft_seq_state_t              state_d, state_q;
    logic [N-1:0]                index_d, index_q;
    logic                        fft_load_d, fft_load_q;
    logic signed [BIT_WIDTH-1:0] din_d, din_q;
    logic [N-1:0]                add_rd_d, add_rd_q;
    logic                        fft_start_d, fft_start_q;
    logic                        busy_d, busy_q;
    logic [15:0]                 frame_count_d, frame_count_q;
    logic                        overrun_d, overrun_q;
    logic                        timeout_err_d, timeout_err_q;

    logic hold_tc;
    logic to_tc;

    // HOLD length: loaded on BUSY->HOLD, counts down to zero while in HOLD.
    seq_counter #(.W(W_HO)) u_hold_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       ((state_q == BUSY) && fft_done),
        .load_value (W_HO'(HOLD_LOAD)),
        .en         ((state_q == HOLD) && !hold_tc),
        .up         (1'b0),
        .term_value ('0),
        .tc         (hold_tc)
    );

    // BUSY watchdog: cleared in START, one step per BUSY cycle. tc marks the
    // TIMEOUT-th BUSY cycle.
    seq_counter #(.W(W_TO)) u_timeout_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (state_q == START),
        .load_value ('0),
        .en         (state_q == BUSY),
        .up         (1'b1),
        .term_value (W_TO'(TIMEOUT - 1)),
        .tc         (to_tc)
    );

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        fft_load_d    = 1'b0;
        din_d         = din_q;
        add_rd_d      = add_rd_q;
        fft_start_d   = 1'b0;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d       = LOAD;
                    index_d       = '0;
                    overrun_d     = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            LOAD: begin
                // Abort wins over a coincident sample.
                if (!enable) begin
                    state_d = IDLE;
                    index_d = '0;
                end else if (sample_valid) begin
                    fft_load_d = 1'b1;
                    din_d      = sample;
                    add_rd_d   = index_q;
                    index_d    = index_q + N'(1);
                    if (index_q == LAST_IDX) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                fft_start_d = 1'b1;
                state_d     = BUSY;
            end
            BUSY: begin
                // enable is ignored here: the frame always completes or times out.
                if (fft_done) begin
                    state_d       = HOLD;
                    frame_count_d = frame_count_q + 16'd1;
                end else if (to_tc) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            HOLD: begin
                if (hold_tc) begin
                    state_d = enable ? LOAD : IDLE;
                    index_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase

        // Samples arriving while the FFT owns the memory are dropped.
        if (sample_valid &&
            ((state_q == START) || (state_q == BUSY) || (state_q == HOLD))) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            index_q       <= '0;
            fft_load_q    <= 1'b0;
            din_q         <= '0;
            add_rd_q      <= '0;
            fft_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            fft_load_q    <= fft_load_d;
            din_q         <= din_d;
            add_rd_q      <= add_rd_d;
            fft_start_q   <= fft_start_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign fft_load    = fft_load_q;
    assign din         = din_q;
    assign add_rd      = add_rd_q;
    assign fft_start   = fft_start_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sequencer
// Directed bench: u_dut runs FFT_SIZE=8, HOLDOFF=2, TIMEOUT=50 through single
// frame, overrun, abort, timeout and reset-in-BUSY; u_b2b runs HOLDOFF=0 with
// a sample every cycle for three back-to-back frames.
// ---------------------------------------------------------------------------
module tb_fft_frame_sequencer;

    localparam int BW = 16;
    localparam int N  = 3;
    localparam int FS = 8;
    localparam int HO = 2;
    localparam int TO = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, enable, sample_valid, fft_done;
    logic signed [BW-1:0] sample;
    logic                 fft_load, fft_start, busy, overrun, timeout_err;
    logic signed [BW-1:0] din;
    logic [N-1:0]         add_rd;
    logic [15:0]          frame_count;

    logic                 b_reset, b_enable, b_sample_valid, b_fft_done;
    logic signed [BW-1:0] b_sample;
    logic                 b_fft_load, b_fft_start, b_busy, b_overrun, b_timeout_err;
    logic signed [BW-1:0] b_din;
    logic [N-1:0]         b_add_rd;
    logic [15:0]          b_frame_count;

    fft_frame_sequencer #(
        .BIT_WIDTH(BW), .N(N), .FFT_SIZE(FS), .HOLDOFF(HO), .TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample(sample), .fft_done(fft_done), .fft_load(fft_load), .din(din),
        .add_rd(add_rd), .fft_start(fft_start), .busy(busy),
        .frame_count(frame_count), .overrun(overrun), .timeout_err(timeout_err)
    );

    fft_frame_sequencer #(
        .BIT_WIDTH(BW), .N(N), .FFT_SIZE(FS), .HOLDOFF(0), .TIMEOUT(TO)
    ) u_b2b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .sample_valid(b_sample_valid),
        .sample(b_sample), .fft_done(b_fft_done), .fft_load(b_fft_load), .din(b_din),
        .add_rd(b_add_rd), .fft_start(b_fft_start), .busy(b_busy),
        .frame_count(b_frame_count), .overrun(b_overrun), .timeout_err(b_timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; returns in the cycle where the write should be visible.
    task automatic strobe(input logic [15:0] val);
        sample_valid = 1'b1;
        sample       = val;
        tick();
        sample_valid = 1'b0;
    endtask

    // Back-to-back strobes for indices first..last, checking each write.
    task automatic load_samples(input int first, input int last, input int base);
        for (int i = first; i <= last; i++) begin
            strobe(16'(base + i));
            check("ld_load", 32'(fft_load), 32'd1);
            check("ld_addr", 32'(add_rd), 32'(i));
            check("ld_din", 32'(din), 32'(base + i));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load"}, 32'(fft_load), 32'd0);
        check({tag, "_start"}, 32'(fft_start), 32'd0);
        check({tag, "_din"}, 32'(din), 32'd0);
        check({tag, "_addr"}, 32'(add_rd), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frames"}, 32'(frame_count), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
        check({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample = '0; fft_done = 1'b0;
        b_reset = 1'b1; b_enable = 1'b0; b_sample_valid = 1'b0; b_sample = '0; b_fft_done = 1'b0;
        repeat (2) tick();
        check_all_zero("rst");

        // ---- single frame, one strobe every 3 cycles ----
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < FS; i++) begin
            strobe(16'(i + 1));
            check("t1_load", 32'(fft_load), 32'd1);
            check("t1_addr", 32'(add_rd), 32'(i));
            check("t1_din", 32'(din), 32'(i + 1));
            check("t1_nostart", 32'(fft_start), 32'd0);
            tick();
            check("t1_load_low", 32'(fft_load), 32'd0);
            check("t1_addr_hold", 32'(add_rd), 32'(i));
            check("t1_start", 32'(fft_start), 32'(i == FS - 1));
            if (i != FS - 1) tick();
        end
        tick();
        check("t1_start_1cyc", 32'(fft_start), 32'd0);
        repeat (18) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check("t1_frames", 32'(frame_count), 32'd1);
        check("t1_hold_busy", 32'(busy), 32'd1);
        repeat (2) tick();
        // first LOAD cycle after a 2-cycle HOLD
        strobe(16'h0011);
        check("t1_reload", 32'(fft_load), 32'd1);
        check("t1_reload_addr", 32'(add_rd), 32'd0);
        check("t1_no_ovr", 32'(overrun), 32'd0);
        load_samples(1, FS - 1, 16'h0010);
        tick();
        check("f2_start", 32'(fft_start), 32'd1);

        // ---- overrun during BUSY and in the last HOLD cycle ----
        tick();
        strobe(16'h0055);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_noload", 32'(fft_load), 32'd0);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check("f2_frames", 32'(frame_count), 32'd2);
        tick();
        strobe(16'h0066);
        check("hold_drop", 32'(fft_load), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // ---- abort after 5 of 8 samples ----
        load_samples(0, 4, 16'h0020);
        enable = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_nostart", 32'(fft_start), 32'd0);
        check("abort_ovr_kept", 32'(overrun), 32'd1);
        tick();
        check("abort_nostart2", 32'(fft_start), 32'd0);
        enable = 1'b1;
        tick();
        check("reen_busy", 32'(busy), 32'd1);
        check("reen_ovr_clr", 32'(overrun), 32'd0);
        load_samples(0, FS - 1, 16'h0030);
        tick();
        check("f3_start", 32'(fft_start), 32'd1);

        // ---- timeout: no fft_done for 50 BUSY cycles ----
        repeat (TO - 1) tick();
        check("tmo_still_busy", 32'(busy), 32'd1);
        check("tmo_not_yet", 32'(timeout_err), 32'd0);
        tick();
        enable = 1'b0;
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_frames", 32'(frame_count), 32'd2);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check("idle_done_ign", 32'(frame_count), 32'd2);
        check("tmo_sticky", 32'(timeout_err), 32'd1);
        strobe(16'h0077);
        check("idle_sv_noload", 32'(fft_load), 32'd0);
        check("idle_sv_no_ovr", 32'(overrun), 32'd0);

        // ---- reset in the middle of BUSY ----
        enable = 1'b1;
        tick();
        check("rb_tmo_clr", 32'(timeout_err), 32'd0);
        load_samples(0, FS - 1, 16'h0040);
        repeat (3) tick();
        strobe(16'h0088);
        check("rb_ovr", 32'(overrun), 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check_all_zero("rb");
        reset    = 1'b0;
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        tick();
        check("rb_late_done", 32'(frame_count), 32'd0);
        check("rb_idle", 32'(busy), 32'd0);

        // ---- back-to-back, HOLDOFF=0, sample every cycle ----
        b_reset        = 1'b0;
        b_sample_valid = 1'b1;
        repeat (2) tick();
        check("b2b_idle_ovr", 32'(b_overrun), 32'd0);
        check("b2b_idle_load", 32'(b_fft_load), 32'd0);
        b_enable   = 1'b1;
        b_fft_done = 1'b1;
        begin
            int loads = 0;
            int exp_addr = 0;
            int cyc = 0;
            logic signed [BW-1:0] sent;
            while (b_frame_count != 16'd3 && cyc < 200) begin
                sent = b_sample;
                tick();
                b_sample = b_sample + 16'sd1;
                cyc++;
                if (b_fft_load) begin
                    check("b2b_addr", 32'(b_add_rd), 32'(exp_addr));
                    check("b2b_din", 32'(b_din), 32'(sent));
                    if (loads == FS - 1) check("b2b_ovr_f1", 32'(b_overrun), 32'd0);
                    loads++;
                    exp_addr = (exp_addr + 1) % FS;
                end
            end
            check("b2b_frames", 32'(b_frame_count), 32'd3);
            check("b2b_loads", 32'(loads), 32'(3 * FS));
            check("b2b_ovr", 32'(b_overrun), 32'd1);
            check("b2b_tmo", 32'(b_timeout_err), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
